counting_scoreboard: RTL and testbench



---
 rtl/counting_scoreboard.sv | 200 ++++++++++++++++++++
 tb/tb_counting_scoreboard.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counting_scoreboard.sv
// Per-register pending-write scoreboard for the scalar and vector register
// files. It tracks outstanding writes with small counters and raises delay_o
// when the instruction at the ibuffer head would hit a hazard.
module counting_scoreboard #(
  parameter int unsigned REG_W     = 6,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned NUM_XWB   = 2,
  parameter int unsigned NUM_VWB   = 2,
  parameter int unsigned ALLOW_WAW = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 chk_rs_en_i,
  input  logic [2:0]                 chk_rs_vec_i,
  input  logic [3*REG_W-1:0]         chk_rs_idx_i,
  input  logic                       chk_mask_i,
  input  logic                       chk_wxd_i,
  input  logic                       chk_wvd_i,
  input  logic [REG_W-1:0]           chk_idxw_i,
  input  logic                       chk_mem_i,
  input  logic                       if_fire_i,
  input  logic                       if_wxd_i,
  input  logic                       if_wvd_i,
  input  logic [REG_W-1:0]           if_idxw_i,
  input  logic [1:0]                 if_branch_i,
  input  logic                       if_barrier_i,
  input  logic                       if_fence_i,
  input  logic [NUM_XWB-1:0]         wb_x_fire_i,
  input  logic [NUM_XWB*REG_W-1:0]   wb_x_idx_i,
  input  logic [NUM_VWB-1:0]         wb_v_fire_i,
  input  logic [NUM_VWB*REG_W-1:0]   wb_v_idx_i,
  input  logic                       br_ctrl_i,
  input  logic                       fence_end_i,
  input  logic                       op_col_in_fire_i,
  input  logic                       op_col_out_fire_i,
  output logic                       delay_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int unsigned NREG  = 1 << REG_W;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  logic [CNT_W-1:0] xcnt [NREG];
  logic [CNT_W-1:0] vcnt [NREG];
  logic [SUM_W-1:0] x_dec [NREG];
  logic [SUM_W-1:0] v_dec [NREG];
  logic [CNT_W:0]   x_res [NREG];
  logic [CNT_W:0]   v_res [NREG];
  logic             x_err_c;
  logic             v_err_c;
  logic             beq;
  logic             opcol;
  logic             fence;
  logic             err;
  logic             src_hz_c;
  logic             dst_hz_c;
  logic             any_pend_c;

  // One counter step: returns {error, next count}; saturates high, clamps low.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic             inc,
                                              input logic [SUM_W-1:0] dec);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] diff;
    sum  = SUM_W'(cnt) + SUM_W'(inc);
    diff = sum - dec;
    if (dec > sum) begin
      return {1'b1, CNT_W'(0)};
    end
    if (diff > {1'b0, CNT_FULL}) begin
      return {1'b1, CNT_FULL};
    end
    return {1'b0, diff[CNT_W-1:0]};
  endfunction

  // Count writeback port hits per register.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      x_dec[r] = '0;
      v_dec[r] = '0;
      for (int unsigned p = 0; p < NUM_XWB; p++) begin
        x_dec[r] = x_dec[r] + SUM_W'(wb_x_fire_i[p] &&
                   (wb_x_idx_i[p*REG_W +: REG_W] == REG_W'(r)));
      end
      for (int unsigned p = 0; p < NUM_VWB; p++) begin
        v_dec[r] = v_dec[r] + SUM_W'(wb_v_fire_i[p] &&
                   (wb_v_idx_i[p*REG_W +: REG_W] == REG_W'(r)));
      end
    end
  end

  // Next counter values and overflow/underflow detection; x0 is hardwired to zero.
  always_comb begin
    x_err_c = 1'b0;
    v_err_c = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      x_res[r] = cnt_step(xcnt[r],
                          if_fire_i && if_wxd_i && (if_idxw_i == REG_W'(r)),
                          x_dec[r]);
      v_res[r] = cnt_step(vcnt[r],
                          if_fire_i && if_wvd_i && (if_idxw_i == REG_W'(r)),
                          v_dec[r]);
      if (r == 0) begin
        x_res[r] = '0;
      end
      x_err_c = x_err_c | x_res[r][CNT_W];
      v_err_c = v_err_c | v_res[r][CNT_W];
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        xcnt[r] <= '0;
        vcnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        xcnt[r] <= x_res[r][CNT_W-1:0];
        vcnt[r] <= v_res[r][CNT_W-1:0];
      end
    end
  end

  // Control-flow flags (set wins over clear) and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beq   <= 1'b0;
      opcol <= 1'b0;
      fence <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (if_fire_i && ((if_branch_i != 2'b00) || if_barrier_i)) begin
        beq <= 1'b1;
      end else if (br_ctrl_i) begin
        beq <= 1'b0;
      end
      if (op_col_in_fire_i) begin
        opcol <= 1'b1;
      end else if (op_col_out_fire_i) begin
        opcol <= 1'b0;
      end
      if (if_fire_i && if_fence_i) begin
        fence <= 1'b1;
      end else if (fence_end_i) begin
        fence <= 1'b0;
      end
      err <= err | x_err_c | v_err_c;
    end
  end

  // Source-operand and destination hazards for the instruction at the ibuffer head.
  always_comb begin
    src_hz_c = 1'b0;
    dst_hz_c = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (chk_rs_en_i[i]) begin
        if (chk_rs_vec_i[i]) begin
          src_hz_c = src_hz_c | (vcnt[chk_rs_idx_i[i*REG_W +: REG_W]] != '0);
        end else begin
          src_hz_c = src_hz_c | (xcnt[chk_rs_idx_i[i*REG_W +: REG_W]] != '0);
        end
      end
    end
    if (chk_mask_i && (vcnt[0] != '0)) begin
      src_hz_c = 1'b1;
    end
    if (ALLOW_WAW != 0) begin
      if (chk_wxd_i && (chk_idxw_i != '0) && (xcnt[chk_idxw_i] == CNT_FULL)) begin
        dst_hz_c = 1'b1;
      end
      if (chk_wvd_i && (vcnt[chk_idxw_i] == CNT_FULL)) begin
        dst_hz_c = 1'b1;
      end
    end else begin
      if (chk_wxd_i && (chk_idxw_i != '0) && (xcnt[chk_idxw_i] != '0)) begin
        dst_hz_c = 1'b1;
      end
      if (chk_wvd_i && (vcnt[chk_idxw_i] != '0)) begin
        dst_hz_c = 1'b1;
      end
    end
  end

  // Any outstanding write in either file.
  always_comb begin
    any_pend_c = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      any_pend_c = any_pend_c | (xcnt[r] != '0) | (vcnt[r] != '0);
    end
  end

  assign delay_o = src_hz_c | dst_hz_c | beq | opcol | (chk_mem_i & fence);
  assign idle_o  = ~any_pend_c & ~beq & ~opcol & ~fence;
  assign err_o   = err;

endmodule

// File: tb/tb_counting_scoreboard.sv
// Scoreboard bench: two scoreboards (WAW stall and WAW allowed) share the same
// stimulus; an integer reference model predicts every cycle's outputs.
module tb_counting_scoreboard;

  localparam int NR   = 64;
  localparam int CMAX = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  chk_rs_en_i;
  logic [2:0]  chk_rs_vec_i;
  logic [17:0] chk_rs_idx_i;
  logic        chk_mask_i;
  logic        chk_wxd_i;
  logic        chk_wvd_i;
  logic [5:0]  chk_idxw_i;
  logic        chk_mem_i;
  logic        if_fire_i;
  logic        if_wxd_i;
  logic        if_wvd_i;
  logic [5:0]  if_idxw_i;
  logic [1:0]  if_branch_i;
  logic        if_barrier_i;
  logic        if_fence_i;
  logic [1:0]  wb_x_fire_i;
  logic [11:0] wb_x_idx_i;
  logic [1:0]  wb_v_fire_i;
  logic [11:0] wb_v_idx_i;
  logic        br_ctrl_i;
  logic        fence_end_i;
  logic        op_col_in_fire_i;
  logic        op_col_out_fire_i;
  logic        delay0, idle0, err0;
  logic        delay1, idle1, err1;

  typedef struct {
    logic d0;
    logic d1;
    logic idle;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int   xm[NR];
  int   vm[NR];
  int   beq_m, opcol_m, fence_m, err_m;
  int   n_vec;
  int   n_err;

  counting_scoreboard #(.ALLOW_WAW(0)) u_dut_waw0 (
    .clk(clk), .rst_n(rst_n),
    .chk_rs_en_i(chk_rs_en_i), .chk_rs_vec_i(chk_rs_vec_i), .chk_rs_idx_i(chk_rs_idx_i),
    .chk_mask_i(chk_mask_i), .chk_wxd_i(chk_wxd_i), .chk_wvd_i(chk_wvd_i),
    .chk_idxw_i(chk_idxw_i), .chk_mem_i(chk_mem_i),
    .if_fire_i(if_fire_i), .if_wxd_i(if_wxd_i), .if_wvd_i(if_wvd_i), .if_idxw_i(if_idxw_i),
    .if_branch_i(if_branch_i), .if_barrier_i(if_barrier_i), .if_fence_i(if_fence_i),
    .wb_x_fire_i(wb_x_fire_i), .wb_x_idx_i(wb_x_idx_i),
    .wb_v_fire_i(wb_v_fire_i), .wb_v_idx_i(wb_v_idx_i),
    .br_ctrl_i(br_ctrl_i), .fence_end_i(fence_end_i),
    .op_col_in_fire_i(op_col_in_fire_i), .op_col_out_fire_i(op_col_out_fire_i),
    .delay_o(delay0), .idle_o(idle0), .err_o(err0)
  );

  counting_scoreboard #(.ALLOW_WAW(1)) u_dut_waw1 (
    .clk(clk), .rst_n(rst_n),
    .chk_rs_en_i(chk_rs_en_i), .chk_rs_vec_i(chk_rs_vec_i), .chk_rs_idx_i(chk_rs_idx_i),
    .chk_mask_i(chk_mask_i), .chk_wxd_i(chk_wxd_i), .chk_wvd_i(chk_wvd_i),
    .chk_idxw_i(chk_idxw_i), .chk_mem_i(chk_mem_i),
    .if_fire_i(if_fire_i), .if_wxd_i(if_wxd_i), .if_wvd_i(if_wvd_i), .if_idxw_i(if_idxw_i),
    .if_branch_i(if_branch_i), .if_barrier_i(if_barrier_i), .if_fence_i(if_fence_i),
    .wb_x_fire_i(wb_x_fire_i), .wb_x_idx_i(wb_x_idx_i),
    .wb_v_fire_i(wb_v_fire_i), .wb_v_idx_i(wb_v_idx_i),
    .br_ctrl_i(br_ctrl_i), .fence_end_i(fence_end_i),
    .op_col_in_fire_i(op_col_in_fire_i), .op_col_out_fire_i(op_col_out_fire_i),
    .delay_o(delay1), .idle_o(idle1), .err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      xm[r] = 0;
      vm[r] = 0;
    end
    beq_m = 0; opcol_m = 0; fence_m = 0; err_m = 0;
  endtask

  function automatic logic model_delay(int waw);
    logic d;
    int   idx;
    d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (chk_rs_en_i[i]) begin
        idx = int'(chk_rs_idx_i[i*6 +: 6]);
        if ((chk_rs_vec_i[i] ? vm[idx] : xm[idx]) != 0) d = 1'b1;
      end
    end
    if (chk_mask_i && vm[0] != 0) d = 1'b1;
    idx = int'(chk_idxw_i);
    if (chk_wxd_i && idx != 0 && (waw != 0 ? xm[idx] == CMAX : xm[idx] != 0)) d = 1'b1;
    if (chk_wvd_i && (waw != 0 ? vm[idx] == CMAX : vm[idx] != 0)) d = 1'b1;
    if (beq_m != 0 || opcol_m != 0 || (chk_mem_i && fence_m != 0)) d = 1'b1;
    return d;
  endfunction

  function automatic logic model_idle();
    int s;
    s = beq_m + opcol_m + fence_m;
    for (int r = 0; r < NR; r++) s += xm[r] + vm[r];
    return s == 0;
  endfunction

  task automatic model_step();
    int dx[NR];
    int dv[NR];
    int n;
    for (int r = 0; r < NR; r++) begin
      dx[r] = 0;
      dv[r] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (wb_x_fire_i[p]) dx[int'(wb_x_idx_i[p*6 +: 6])]++;
      if (wb_v_fire_i[p]) dv[int'(wb_v_idx_i[p*6 +: 6])]++;
    end
    for (int r = 1; r < NR; r++) begin
      n = xm[r] - dx[r] + ((if_fire_i && if_wxd_i && int'(if_idxw_i) == r) ? 1 : 0);
      if (n < 0) begin n = 0; err_m = 1; end
      if (n > CMAX) begin n = CMAX; err_m = 1; end
      xm[r] = n;
    end
    for (int r = 0; r < NR; r++) begin
      n = vm[r] - dv[r] + ((if_fire_i && if_wvd_i && int'(if_idxw_i) == r) ? 1 : 0);
      if (n < 0) begin n = 0; err_m = 1; end
      if (n > CMAX) begin n = CMAX; err_m = 1; end
      vm[r] = n;
    end
    if (if_fire_i && (if_branch_i != 2'b00 || if_barrier_i)) beq_m = 1;
    else if (br_ctrl_i) beq_m = 0;
    if (op_col_in_fire_i) opcol_m = 1;
    else if (op_col_out_fire_i) opcol_m = 0;
    if (if_fire_i && if_fence_i) fence_m = 1;
    else if (fence_end_i) fence_m = 0;
  endtask

  // ---------------- monitor ----------------
  task automatic check(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("delay_waw0", delay0, e.d0);
      check("delay_waw1", delay1, e.d1);
      check("idle_waw0", idle0, e.idle);
      check("idle_waw1", idle1, e.idle);
      check("err_waw0", err0, e.err);
      check("err_waw1", err1, e.err);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic clr_in();
    chk_rs_en_i = '0; chk_rs_vec_i = '0; chk_rs_idx_i = '0; chk_mask_i = 1'b0;
    chk_wxd_i = 1'b0; chk_wvd_i = 1'b0; chk_idxw_i = '0; chk_mem_i = 1'b0;
    if_fire_i = 1'b0; if_wxd_i = 1'b0; if_wvd_i = 1'b0; if_idxw_i = '0;
    if_branch_i = '0; if_barrier_i = 1'b0; if_fence_i = 1'b0;
    wb_x_fire_i = '0; wb_x_idx_i = '0; wb_v_fire_i = '0; wb_v_idx_i = '0;
    br_ctrl_i = 1'b0; fence_end_i = 1'b0;
    op_col_in_fire_i = 1'b0; op_col_out_fire_i = 1'b0;
  endtask

  // Predict this cycle's outputs, advance the model, move to the next cycle.
  task automatic cycle();
    exp_t e;
    if (!rst_n) model_reset();
    e.d0   = model_delay(0);
    e.d1   = model_delay(1);
    e.idle = model_idle();
    e.err  = err_m[0];
    exp_q.push_back(e);
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic issue(logic vec, int idx);
    if_fire_i = 1'b1;
    if (vec) if_wvd_i = 1'b1;
    else if_wxd_i = 1'b1;
    if_idxw_i = 6'(idx);
  endtask

  task automatic wb(int port, logic vec, int idx);
    if (vec) begin
      wb_v_fire_i[port] = 1'b1;
      wb_v_idx_i[port*6 +: 6] = 6'(idx);
    end else begin
      wb_x_fire_i[port] = 1'b1;
      wb_x_idx_i[port*6 +: 6] = 6'(idx);
    end
  endtask

  task automatic rd_chk(int op, logic vec, int idx);
    chk_rs_en_i[op] = 1'b1;
    chk_rs_vec_i[op] = vec;
    chk_rs_idx_i[op*6 +: 6] = 6'(idx);
  endtask

  task automatic wr_chk(logic vec, int idx);
    if (vec) chk_wvd_i = 1'b1;
    else chk_wxd_i = 1'b1;
    chk_idxw_i = 6'(idx);
  endtask

  task automatic rand_cycle();
    int tx[NR];
    int tv[NR];
    int idx;
    logic vec;
    tx = xm;
    tv = vm;
    chk_rs_en_i  = 3'($urandom);
    chk_rs_vec_i = 3'($urandom);
    for (int i = 0; i < 3; i++) chk_rs_idx_i[i*6 +: 6] = 6'($urandom_range(0, 7));
    chk_mask_i = ($urandom_range(0, 3) == 0);
    chk_wxd_i  = 1'($urandom);
    chk_wvd_i  = 1'($urandom);
    chk_idxw_i = 6'($urandom_range(0, 7));
    chk_mem_i  = 1'($urandom);
    if_wxd_i   = 1'($urandom);
    if_wvd_i   = 1'($urandom);
    if_idxw_i  = 6'($urandom_range(0, 7));
    if_fire_i  = 1'($urandom);
    if (if_wxd_i && xm[int'(if_idxw_i)] == CMAX) if_fire_i = 1'b0;
    if (if_wvd_i && vm[int'(if_idxw_i)] == CMAX) if_fire_i = 1'b0;
    if_branch_i  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    if_barrier_i = ($urandom_range(0, 11) == 0);
    if_fence_i   = ($urandom_range(0, 7) == 0);
    for (int p = 0; p < 2; p++) begin
      idx = $urandom_range(1, 7);
      wb_x_idx_i[p*6 +: 6] = 6'(idx);
      if ($urandom_range(0, 1) == 1 && tx[idx] > 0) begin
        wb_x_fire_i[p] = 1'b1;
        tx[idx]--;
      end
      idx = $urandom_range(0, 7);
      wb_v_idx_i[p*6 +: 6] = 6'(idx);
      if ($urandom_range(0, 1) == 1 && tv[idx] > 0) begin
        wb_v_fire_i[p] = 1'b1;
        tv[idx]--;
      end
    end
    vec = 1'b0;
    br_ctrl_i         = ($urandom_range(0, 3) == 0) | vec;
    fence_end_i       = ($urandom_range(0, 3) == 0);
    op_col_in_fire_i  = ($urandom_range(0, 5) == 0);
    op_col_out_fire_i = ($urandom_range(0, 2) == 0);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr_in();
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // issue x5, read-check stalls next cycle, writeback releases one cycle later
    issue(0, 5); rd_chk(0, 0, 5); cycle();
    rd_chk(0, 0, 5); cycle();
    rd_chk(0, 0, 5); wb(0, 0, 5); cycle();
    rd_chk(0, 0, 5); cycle();

    // three writes to v7 saturate; WAW-allowed stalls only when full
    for (int k = 0; k < 3; k++) begin
      issue(1, 7); wr_chk(1, 7); cycle();
    end
    wr_chk(1, 7); cycle();
    wr_chk(1, 7); wb(1, 1, 7); cycle();
    wr_chk(1, 7); cycle();
    rd_chk(2, 1, 7); cycle();
    wb(0, 1, 7); wb(1, 1, 7); rd_chk(1, 1, 7); cycle();
    rd_chk(1, 1, 7); cycle();

    // same-cycle issue+writeback on x3, then dual writeback on x3
    issue(0, 3); cycle();
    issue(0, 3); wb(1, 0, 3); rd_chk(0, 0, 3); cycle();
    rd_chk(0, 0, 3); cycle();
    issue(0, 3); cycle();
    wb(0, 0, 3); wb(1, 0, 3); rd_chk(0, 0, 3); cycle();
    rd_chk(0, 0, 3); wr_chk(0, 3); cycle();

    // x0 writes are dropped
    issue(0, 0); cycle();
    rd_chk(0, 0, 0); wr_chk(0, 0); cycle();

    // fence gates memory ops only
    if_fire_i = 1'b1; if_fence_i = 1'b1; cycle();
    chk_mem_i = 1'b1; cycle();
    rd_chk(0, 0, 1); cycle();
    fence_end_i = 1'b1; chk_mem_i = 1'b1; cycle();
    chk_mem_i = 1'b1; cycle();

    // branch set beats br_ctrl clear; barrier; operand collector
    if_fire_i = 1'b1; if_branch_i = 2'b10; br_ctrl_i = 1'b1; cycle();
    cycle();
    br_ctrl_i = 1'b1; cycle();
    cycle();
    if_fire_i = 1'b1; if_barrier_i = 1'b1; cycle();
    br_ctrl_i = 1'b1; cycle();
    op_col_in_fire_i = 1'b1; cycle();
    op_col_out_fire_i = 1'b1; cycle();
    cycle();

    // stray writeback on empty v9 raises sticky error
    wb(0, 1, 9); cycle();
    rd_chk(0, 1, 9); cycle();
    cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle();

    // randomized traffic with a reset in the middle
    for (int k = 0; k < 300; k++) rand_cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle();
    for (int k = 0; k < 300; k++) rand_cycle();

    // overflow: four writes to v7 without writeback
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle();
    for (int k = 0; k < 4; k++) begin
      issue(1, 7); wr_chk(1, 7); cycle();
    end
    rd_chk(0, 1, 7); cycle();
    cycle();

    #20;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
